// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, parity modes, stop-bit options.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int STOP_ONE = 1;
  localparam int STOP_TWO = 2;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [7:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: takes one word per valid/ready handshake and shifts it
// out on tx as start, LSB-first data, optional parity and stop bits, one bit per baud tick.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              baud_tick,
  output logic              baud_en,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic              STOP_LAST = (STOP_BITS == STOP_TWO) ? 1'b1 : 1'b0;
  localparam logic              PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_tx_state_e    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              baud_en_q, baud_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        par_src;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    done_d     = 1'b0;
    par_src    = '0;
    par_src[DATA_W-1:0] = tx_data;

    case (state_q)
      ST_IDLE: begin
        // Ticks are ignored here; the generator is held cleared anyway.
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = calc_parity(par_src, PAR_MODE);
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            stop_cnt_d = 1'b0;
            state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line value is decoded from the next state so tx changes together with the state.
  always_comb begin
    tx_d      = 1'b1;
    baud_en_d = (state_d != ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      baud_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      baud_en_q  <= baud_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign baud_en  = baud_en_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four configurations (8N1, 8E1, 8O1, 8N2), each fed by a
// divisor-3 baud generator model, checked against hand-derived frame timing.
module tb_uart_tx_ctrl;

  localparam int D = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] valid_v = 4'h0;
  logic [3:0] force_v = 4'h0;
  wire  [3:0] tick_v, ready_v, en_v, tx_v, busy_v, done_v;

  int errors = 0;
  int checks = 0;

  logic cap_tx    [1:100];
  logic cap_done  [1:100];
  logic cap_busy  [1:100];
  logic cap_ready [1:100];
  logic cap_en    [1:100];

  always #5 clock = ~clock;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      logic [1:0] cnt;
      logic       gen_tick;

      // Registered tick: first tick D+2 cycles after enable rises, then every D+1.
      always_ff @(posedge clock) begin
        if (reset || !en_v[gi]) begin
          cnt      <= 2'd0;
          gen_tick <= 1'b0;
        end else begin
          gen_tick <= (cnt == 2'(D));
          cnt      <= (cnt == 2'(D)) ? 2'd0 : cnt + 2'd1;
        end
      end

      assign tick_v[gi] = gen_tick | force_v[gi];

      uart_tx_ctrl #(
        .DATA_W    (8),
        .PARITY_EN ((gi == 1 || gi == 2) ? 1 : 0),
        .PARITY_ODD((gi == 2) ? 1 : 0),
        .STOP_BITS ((gi == 3) ? 2 : 1)
      ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (valid_v[gi]),
        .tx_ready (ready_v[gi]),
        .baud_tick(tick_v[gi]),
        .baud_en  (en_v[gi]),
        .tx       (tx_v[gi]),
        .busy     (busy_v[gi]),
        .done     (done_v[gi])
      );
    end
  endgenerate

  task automatic send(input int idx, input logic [7:0] data);
    @(negedge clock);
    tx_data      = data;
    valid_v[idx] = 1'b1;
  endtask

  // Offset k is the k-th cycle after the handshake cycle.
  task automatic capture(input int idx, input int first, input int last, input int drop_at);
    for (int k = first; k <= last; k++) begin
      @(negedge clock);
      cap_tx[k]    = tx_v[idx];
      cap_done[k]  = done_v[idx];
      cap_busy[k]  = busy_v[idx];
      cap_ready[k] = ready_v[idx];
      cap_en[k]    = en_v[idx];
      if (k == drop_at) valid_v[idx] = 1'b0;
    end
  endtask

  // Expected line level k cycles after a handshake: start bit D+2 cycles, others D+1.
  function automatic logic exp_bit(input int k, input logic [7:0] data, input int par_en,
                                   input logic par_bit, input int nbits);
    int b;
    b = (k <= D + 2) ? 0 : (k - (D + 2) - 1) / (D + 1) + 1;
    if (b >= nbits) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return data[b-1];
    if (b == 9 && par_en != 0) return par_bit;
    return 1'b1;
  endfunction

  function automatic int frame_bad(input int base, input logic [7:0] data, input int par_en,
                                   input logic par_bit, input int nbits);
    for (int k = 1; k <= (D + 1) * nbits + 2; k++)
      if (cap_tx[base+k] !== exp_bit(k, data, par_en, par_bit, nbits)) return base + k;
    return 0;
  endfunction

  function automatic int first_done(input int from, input int to);
    for (int k = from; k <= to; k++)
      if (cap_done[k] === 1'b1) return k;
    return 0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (tx_v !== 4'hF) begin errors++; $display("FAIL reset_tx got=%b exp=1111", tx_v); end
    checks++; if (ready_v !== 4'hF) begin errors++; $display("FAIL reset_ready got=%b exp=1111", ready_v); end
    checks++; if (en_v !== 4'h0) begin errors++; $display("FAIL reset_baud_en got=%b exp=0000", en_v); end
    checks++; if (busy_v !== 4'h0) begin errors++; $display("FAIL reset_busy got=%b exp=0000", busy_v); end
    checks++; if (done_v !== 4'h0) begin errors++; $display("FAIL reset_done got=%b exp=0000", done_v); end
    force_v = 4'hF;
    repeat (3) @(negedge clock);
    force_v = 4'h0;
    @(negedge clock);
    checks++;
    if (tx_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0 || ready_v !== 4'hF || en_v !== 4'h0) begin
      errors++;
      $display("FAIL idle_ticks got tx=%b busy=%b done=%b ready=%b en=%b exp tx=1111 busy=0000 done=0000 ready=1111 en=0000",
               tx_v, busy_v, done_v, ready_v, en_v);
    end
    $display("test_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_8n1();
    int bad, dpos;
    logic busy_ok;
    send(0, 8'hA5);
    capture(0, 1, 43, 1);
    bad = frame_bad(0, 8'hA5, 0, 1'b0, 10);
    checks++; if (bad != 0) begin errors++; $display("FAIL 8n1_frame first bad offset=%0d got=%b exp=%b", bad, cap_tx[bad], exp_bit(bad, 8'hA5, 0, 1'b0, 10)); end
    dpos = first_done(1, 43);
    checks++; if (dpos != 42) begin errors++; $display("FAIL 8n1_done_offset got=%0d exp=42", dpos); end
    checks++; if (cap_done[43] !== 1'b0) begin errors++; $display("FAIL 8n1_done_pulse got=%b exp=0", cap_done[43]); end
    busy_ok = 1'b1;
    for (int k = 1; k <= 41; k++) if (cap_busy[k] !== 1'b1) busy_ok = 1'b0;
    checks++; if (!busy_ok || cap_busy[42] !== 1'b0) begin errors++; $display("FAIL 8n1_busy got whole=%b at42=%b exp whole=1 at42=0", busy_ok, cap_busy[42]); end
    checks++; if (cap_en[1] !== 1'b1 || cap_en[41] !== 1'b1 || cap_en[42] !== 1'b0) begin
      errors++; $display("FAIL 8n1_baud_en got %b%b%b exp 110", cap_en[1], cap_en[41], cap_en[42]); end
    checks++; if (cap_ready[41] !== 1'b0 || cap_ready[42] !== 1'b1) begin
      errors++; $display("FAIL 8n1_ready got %b%b exp 01", cap_ready[41], cap_ready[42]); end
    $display("test_8n1: tx 0xA5 done@%0d checks=%0d errors=%0d", dpos, checks, errors);
  endtask

  task automatic test_parity();
    int bad, dpos;
    send(1, 8'h07);
    capture(1, 1, 47, 1);
    bad = frame_bad(0, 8'h07, 1, 1'b1, 11);
    checks++; if (bad != 0) begin errors++; $display("FAIL even_frame first bad offset=%0d got=%b", bad, cap_tx[bad]); end
    checks++; if (cap_tx[39] !== 1'b1) begin errors++; $display("FAIL even_parity_bit got=%b exp=1", cap_tx[39]); end
    dpos = first_done(1, 47);
    checks++; if (dpos != 46) begin errors++; $display("FAIL even_done_offset got=%0d exp=46", dpos); end
    send(2, 8'h07);
    capture(2, 1, 47, 1);
    bad = frame_bad(0, 8'h07, 1, 1'b0, 11);
    checks++; if (bad != 0) begin errors++; $display("FAIL odd_frame first bad offset=%0d got=%b", bad, cap_tx[bad]); end
    checks++; if (cap_tx[39] !== 1'b0) begin errors++; $display("FAIL odd_parity_bit got=%b exp=0", cap_tx[39]); end
    dpos = first_done(1, 47);
    checks++; if (dpos != 46) begin errors++; $display("FAIL odd_done_offset got=%0d exp=46", dpos); end
    $display("test_parity: tx 0x07 even/odd checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_two_stop();
    int bad, dpos;
    logic busy_ok;
    send(3, 8'hFF);
    capture(3, 1, 47, 1);
    bad = frame_bad(0, 8'hFF, 0, 1'b0, 11);
    checks++; if (bad != 0) begin errors++; $display("FAIL stop2_frame first bad offset=%0d got=%b", bad, cap_tx[bad]); end
    dpos = first_done(1, 47);
    checks++; if (dpos != 46) begin errors++; $display("FAIL stop2_done_offset got=%0d exp=46", dpos); end
    busy_ok = 1'b1;
    for (int k = 1; k <= 45; k++) if (cap_busy[k] !== 1'b1) busy_ok = 1'b0;
    checks++; if (!busy_ok || cap_busy[46] !== 1'b0) begin errors++; $display("FAIL stop2_busy got whole=%b at46=%b exp whole=1 at46=0", busy_ok, cap_busy[46]); end
    $display("test_two_stop: tx 0xFF done@%0d checks=%0d errors=%0d", dpos, checks, errors);
  endtask

  task automatic test_back_to_back();
    int bad, ndone;
    send(0, 8'h3C);
    capture(0, 1, 1, 0);
    tx_data = 8'hC3;
    capture(0, 2, 43, 43);
    capture(0, 44, 87, 0);
    bad = frame_bad(0, 8'h3C, 0, 1'b0, 10);
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame1 first bad offset=%0d got=%b", bad, cap_tx[bad]); end
    checks++; if (cap_done[42] !== 1'b1 || cap_ready[42] !== 1'b1) begin
      errors++; $display("FAIL b2b_done1 got done=%b ready=%b exp 1 1", cap_done[42], cap_ready[42]); end
    checks++; if (cap_tx[42] !== 1'b1 || cap_tx[43] !== 1'b0) begin
      errors++; $display("FAIL b2b_gap got tx42=%b tx43=%b exp 1 0", cap_tx[42], cap_tx[43]); end
    bad = frame_bad(42, 8'hC3, 0, 1'b0, 10);
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_frame2 first bad offset=%0d got=%b", bad, cap_tx[bad]); end
    ndone = 0;
    for (int k = 1; k <= 87; k++) if (cap_done[k] === 1'b1) ndone++;
    checks++; if (ndone != 2 || cap_done[84] !== 1'b1) begin
      errors++; $display("FAIL b2b_done_count got=%0d done84=%b exp 2 1", ndone, cap_done[84]); end
    $display("test_back_to_back: tx 0x3C,0xC3 checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_mid_reset();
    int bad, dpos;
    send(0, 8'h5A);
    capture(0, 1, 23, 1);
    checks++; if (cap_tx[23] !== 1'b1) begin errors++; $display("FAIL midrst_bit4 got=%b exp=1", cap_tx[23]); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (tx_v[0] !== 1'b1 || en_v[0] !== 1'b0 || ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got tx=%b en=%b ready=%b busy=%b exp 1 0 1 0", tx_v[0], en_v[0], ready_v[0], busy_v[0]); end
    send(0, 8'h96);
    capture(0, 1, 43, 1);
    bad = frame_bad(0, 8'h96, 0, 1'b0, 10);
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_frame first bad offset=%0d got=%b", bad, cap_tx[bad]); end
    dpos = first_done(1, 43);
    checks++; if (dpos != 42) begin errors++; $display("FAIL midrst_done_offset got=%0d exp=42", dpos); end
    $display("test_mid_reset: tx 0x96 after reset checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
